// File: rtl/axi_rx_dispatch.sv
// axi_rx_dispatch: routes packets from a single rx beat stream into NUM_CH
// per-channel FIFOs, keyed by a type field in the header (first) beat.
// Packets whose type is >= NUM_CH are dropped as a whole.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   rx_*                  input beat stream (valid/ready handshake)
//   ch_*                  per-channel output streams, channel k at slice k
//   ch_level              per-channel FIFO occupancy
//   drop_count            dropped-packet counter
//
// Build option: define AXI_RX_DISPATCH_STATS_EN to get a saturating
// drop_count register; otherwise drop_count is tied to 0.

// One channel FIFO. Storage is not reset; only pointers and level are.
module axi_rx_dispatch_fifo #(
    parameter int EW    = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_i,
    input  logic [EW-1:0] wdata_i,
    input  logic          rd_ready_i,
    output logic [EW-1:0] rdata_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [LW-1:0] lvl_q;
    logic          rd;

    assign valid_o = (lvl_q != '0);
    assign full_o  = (lvl_q == LW'(DEPTH));
    assign level_o = lvl_q;
    assign rdata_o = mem_q[rp_q];
    assign rd      = valid_o & rd_ready_i;

    always_ff @(posedge clk) begin
        if (wr_i) mem_q[wp_q] <= wdata_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (wr_i) wp_q <= wp_q + 1'b1;
            if (rd)   rp_q <= rp_q + 1'b1;
            case ({wr_i, rd})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: lvl_q <= lvl_q;
            endcase
        end
    end
endmodule

module axi_rx_dispatch #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 5,
    parameter int FIFO_DEPTH = 16,
    parameter int TYPE_LSB   = 0,
    parameter int TYPE_W     = 3
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [DATA_WIDTH*8-1:0]                      rx_data,
    input  logic [3:0]                                   rx_connection_id,
    input  logic                                         rx_last,
    input  logic                                         rx_valid,
    output logic                                         rx_ready,
    output logic [NUM_CH*DATA_WIDTH*8-1:0]               ch_data,
    output logic [NUM_CH*4-1:0]                          ch_connection_id,
    output logic [NUM_CH-1:0]                            ch_last,
    output logic [NUM_CH-1:0]                            ch_valid,
    input  logic [NUM_CH-1:0]                            ch_ready,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]     ch_level,
    output logic [15:0]                                  drop_count
);
    localparam int DW = DATA_WIDTH * 8;
    localparam int EW = DW + 5;               // {conn_id, last, data}
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0] full, wr_en;
    logic [31:0]     t_w;
    logic [SW-1:0]   t_sel;
    logic            hdr_ok, rdy, drop_inc;

    assign t_w    = 32'(rx_data[TYPE_LSB +: TYPE_W]);
    assign t_sel  = t_w[SW-1:0];
    assign hdr_ok = (t_w < 32'(NUM_CH));

    // Ready is forced low while reset is asserted.
    assign rx_ready = reset_n & rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rdy      = 1'b0;
        wr_en    = '0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_ok) begin
                    rdy = ~full[t_sel];
                    if (rx_valid && rdy) begin
                        wr_en[t_sel] = 1'b1;
                        sel_d        = t_sel;
                        if (!rx_last) state_d = FWD;
                    end
                end else begin
                    rdy = 1'b1;
                    if (rx_valid) begin
                        drop_inc = 1'b1;
                        if (!rx_last) state_d = DROP;
                    end
                end
            end
            FWD: begin
                rdy = ~full[sel_q];
                if (rx_valid && rdy) begin
                    wr_en[sel_q] = 1'b1;
                    if (rx_last) state_d = IDLE;
                end
            end
            DROP: begin
                rdy = 1'b1;
                if (rx_valid && rx_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [EW-1:0] head;
        axi_rx_dispatch_fifo #(.EW(EW), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_i       (wr_en[k]),
            .wdata_i    ({rx_connection_id, rx_last, rx_data}),
            .rd_ready_i (ch_ready[k]),
            .rdata_o    (head),
            .valid_o    (ch_valid[k]),
            .full_o     (full[k]),
            .level_o    (ch_level[k*LW +: LW])
        );
        assign ch_data[k*DW +: DW]        = head[DW-1:0];
        assign ch_last[k]                 = head[DW];
        assign ch_connection_id[k*4 +: 4] = head[DW+4:DW+1];
    end

`ifdef AXI_RX_DISPATCH_STATS_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                             drop_cnt_q <= '0;
        else if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
    assign drop_count = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign drop_count      = '0;
`endif
endmodule

// File: tb/tb_axi_rx_dispatch.sv
// Randomized + directed bench for axi_rx_dispatch (default parameters).
// A packet-level queue model predicts rx_ready, every channel head, levels
// and drop_count each cycle.
module tb_axi_rx_dispatch;
    localparam int NCH = 5;
    localparam int DEP = 16;
    localparam int DW  = 128;
    localparam int LW  = $clog2(DEP) + 1;
`ifdef AXI_RX_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] d;
        logic [3:0]    c;
        logic          l;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [DW-1:0]      rx_data;
    logic [3:0]         rx_connection_id;
    logic               rx_last, rx_valid, rx_ready;
    logic [NCH*DW-1:0]  ch_data;
    logic [NCH*4-1:0]   ch_connection_id;
    logic [NCH-1:0]     ch_last, ch_valid, ch_ready;
    logic [NCH*LW-1:0]  ch_level;
    logic [15:0]        drop_count;

    axi_rx_dispatch dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data),
        .rx_connection_id(rx_connection_id), .rx_last(rx_last),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .ch_data(ch_data),
        .ch_connection_id(ch_connection_id), .ch_last(ch_last),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_level(ch_level),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int ncmp = 0, nerr = 0;

    task automatic chk(string tag, logic [135:0] got, logic [135:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: what each channel should hold, packet routing mode.
    beat_t mq [NCH][$];
    beat_t bq [$];            // beats waiting to be offered on rx
    int    mode = 0;          // 0 = expecting header, 1 = routing, 2 = discarding
    int    msel = 0;
    int    mdrop = 0;

    function automatic bit model_ready();
        int t;
        if (!reset_n) return 1'b0;
        if (mode == 2) return 1'b1;
        if (mode == 1) return mq[msel].size() < DEP;
        t = int'(rx_data[2:0]);
        if (t >= NCH) return 1'b1;
        return mq[t].size() < DEP;
    endfunction

    function automatic void model_accept(beat_t b);
        int t;
        if (mode == 0) begin
            t = int'(b.d[2:0]);
            if (t < NCH) begin
                mq[t].push_back(b);
                msel = t;
                mode = b.l ? 0 : 1;
            end else begin
                if (STATS && mdrop < 65535) mdrop++;
                mode = b.l ? 0 : 2;
            end
        end else if (mode == 1) begin
            mq[msel].push_back(b);
            if (b.l) mode = 0;
        end else if (b.l) begin
            mode = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) mq[k].delete();
        mode = 0; msel = 0; mdrop = 0;
    endfunction

    // Check all outputs at the negedge, then advance model on the posedge.
    task automatic step(output bit fire);
        bit    erdy;
        bit    [NCH-1:0] pop;
        beat_t b, h;
        @(negedge clk);
        erdy = model_ready();
        chk("rx_ready", rx_ready, erdy);
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("ch_valid%0d", k), ch_valid[k], mq[k].size() != 0);
            chk($sformatf("ch_level%0d", k), ch_level[k*LW +: LW], mq[k].size());
            pop[k] = (mq[k].size() != 0) && ch_ready[k];
            if (mq[k].size() != 0) begin
                h = mq[k][0];
                chk($sformatf("ch_data%0d", k), ch_data[k*DW +: DW], h.d);
                chk($sformatf("ch_conn%0d", k), ch_connection_id[k*4 +: 4], h.c);
                chk($sformatf("ch_last%0d", k), ch_last[k], h.l);
            end
        end
        chk("drop_count", drop_count, mdrop);
        fire = rx_valid && erdy;
        b.d = rx_data; b.c = rx_connection_id; b.l = rx_last;
        @(posedge clk);
        for (int k = 0; k < NCH; k++) if (pop[k]) void'(mq[k].pop_front());
        if (fire) model_accept(b);
        #1;
    endtask

    task automatic cyc(bit gaps);
        bit fire;
        if (bq.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
            rx_valid = 1'b1;
            rx_data = bq[0].d; rx_connection_id = bq[0].c; rx_last = bq[0].l;
        end else begin
            rx_valid = 1'b0;
            rx_data = {$urandom, $urandom, $urandom, $urandom};
            rx_connection_id = 4'($urandom); rx_last = 1'($urandom);
        end
        step(fire);
        if (fire) void'(bq.pop_front());
    endtask

    task automatic run(int n, bit gaps);
        for (int i = 0; i < n; i++) cyc(gaps);
    endtask

    // Type field lives in the low bits of the header beat.
    task automatic push_pkt(int typ, logic [3:0] conn, int n, bit seq, logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = seq ? base + DW'(i) : {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) b.d[2:0] = 3'(typ);
            b.c = conn;
            b.l = (i == n - 1);
            bq.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_rx_ready"}, rx_ready, 1'b0);
        chk({tag, "_ch_valid"}, ch_valid, '0);
        chk({tag, "_ch_level"}, ch_level, '0);
        chk({tag, "_drop"}, drop_count, 16'h0);
    endtask

    initial begin
        int cycles;
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_connection_id = '0;
        rx_last = 1'b0; ch_ready = '0;
        #2;
        check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();

        // V1: 3-beat type-2 packet
        ch_ready = '1;
        push_pkt(2, 4'h5, 3, 1'b1, 'hA0);
        run(6, 1'b0);

        // V2: stalled channel 1 fills at 16 beats, then drains
        ch_ready = 5'b11101;
        push_pkt(1, 4'h3, 20, 1'b0, '0);
        run(25, 1'b0);
        chk("v2_level1", ch_level[1*LW +: LW], 16);
        chk("v2_ready", rx_ready, 1'b0);
        chk("v2_pending", bq.size(), 4);
        ch_ready = '1;
        run(30, 1'b0);
        chk("v2_pending_end", bq.size(), 0);

        // V3: dropped type-6 packet, then a type-0 packet
        push_pkt(6, 4'h9, 4, 1'b0, '0);
        push_pkt(0, 4'h2, 1, 1'b0, '0);
        run(10, 1'b0);
        chk("v3_drop", drop_count, STATS ? 16'd1 : 16'd0);

        // V4: channel 3 full and stalled does not block channel 0
        ch_ready = 5'b10111;
        push_pkt(3, 4'h7, 16, 1'b0, '0);
        push_pkt(0, 4'h1, 2, 1'b0, '0);
        run(30, 1'b0);
        chk("v4_level3", ch_level[3*LW +: LW], 16);
        chk("v4_level0", ch_level[0*LW +: LW], 0);
        chk("v4_pending", bq.size(), 0);
        ch_ready = '1;
        run(20, 1'b0);

        // V5: reset with 5 beats of a type-4 packet buffered
        ch_ready = 5'b01111;
        push_pkt(4, 4'hC, 8, 1'b0, '0);
        run(5, 1'b0);
        chk("v5_level4", ch_level[4*LW +: LW], 5);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("v5");
        model_reset();
        bq.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        ch_ready = '1;
        push_pkt(2, 4'hE, 2, 1'b0, '0);
        run(6, 1'b0);

        // Random traffic with random backpressure and input gaps
        for (int p = 0; p < 60; p++)
            push_pkt($urandom_range(7), 4'($urandom), $urandom_range(1, 6), 1'b0, '0);
        cycles = 0;
        while (bq.size() != 0 && cycles < 3000) begin
            ch_ready = NCH'($urandom) | NCH'($urandom);
            cyc(1'b1);
            cycles++;
        end
        chk("rand_pending", bq.size(), 0);
        ch_ready = '1;
        run(20, 1'b0);

        // V6: saturate drop_count with 65536 single-beat invalid packets
        rx_valid = 1'b1; rx_data = DW'(7); rx_last = 1'b1; rx_connection_id = '0;
        repeat (65536) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (STATS) mdrop = (mdrop + 65536 > 65535) ? 65535 : mdrop + 65536;
        run(2, 1'b0);
        chk("v6_drop", drop_count, STATS ? 16'hFFFF : 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
